knap_search_ctrl: RTL and testbench

Exhaustive-search controller for the multi-constraint knapsack checker. It holds a programmable item table and thresholds, enumerates every item subset in ascending binary order, and evaluates each subset through a one-stage pipelined evaluator. It tracks the best feasible subset and the count of feasible subsets, and reports them with a start/done handshake. It sits between the host/config interface and the knapsack constraint datapath.

---
 rtl/knap_pkg.sv | 26 ++
 rtl/knap_search_ctrl_if.sv | 41 ++++
 rtl/knap_eval.sv | 56 +++++
 rtl/knap_search_ctrl.sv | 160 ++++++++++++++++
 tb/tb_knap_search_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/knap_pkg.sv
// Shared types and constants for the knapsack exhaustive-search controller.
package knap_pkg;

  localparam int unsigned KNAP_N_ITEMS = 20;
  localparam int unsigned KNAP_ATTR_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } knap_state_e;

  typedef struct packed {
    logic [KNAP_ATTR_W-1:0] value;
    logic [KNAP_ATTR_W-1:0] weight;
    logic [KNAP_ATTR_W-1:0] volume;
  } item_t;

  // Sum of n_items attributes of attr_w bits never overflows this width.
  function automatic int unsigned knap_sum_w(input int unsigned attr_w,
                                             input int unsigned n_items);
    return attr_w + $clog2(n_items + 1);
  endfunction

endpackage

// File: rtl/knap_search_ctrl_if.sv
// Host-side configuration, threshold and start/done handshake bundle.
interface knap_search_ctrl_if
  import knap_pkg::*;
#(
  parameter int unsigned N_ITEMS = KNAP_N_ITEMS,
  parameter int unsigned ATTR_W  = KNAP_ATTR_W,
  parameter int unsigned SUM_W   = knap_sum_w(ATTR_W, N_ITEMS),
  parameter int unsigned IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) ();

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ATTR_W-1:0] cfg_value;
  logic [ATTR_W-1:0] cfg_weight;
  logic [ATTR_W-1:0] cfg_volume;
  logic [SUM_W-1:0]  min_value;
  logic [SUM_W-1:0]  max_weight;
  logic [SUM_W-1:0]  max_volume;
  logic              first_only;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              found;
  logic [N_ITEMS-1:0] best_sel;
  logic [SUM_W-1:0]  best_value;
  logic [N_ITEMS:0]  feas_count;

  modport master (
    output cfg_we, cfg_idx, cfg_value, cfg_weight, cfg_volume,
    output min_value, max_weight, max_volume, first_only, start, abort,
    input  busy, done, found, best_sel, best_value, feas_count
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_value, cfg_weight, cfg_volume,
    input  min_value, max_weight, max_volume, first_only, start, abort,
    output busy, done, found, best_sel, best_value, feas_count
  );

endinterface

// File: rtl/knap_eval.sv
// One-stage evaluator: masked value/weight/volume sums and feasibility of a subset.
module knap_eval
  import knap_pkg::*;
#(
  parameter int unsigned N_ITEMS = KNAP_N_ITEMS,
  parameter int unsigned SUM_W   = knap_sum_w(KNAP_ATTR_W, N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  item_t              items [N_ITEMS],
  input  logic               in_vld,
  input  logic [N_ITEMS-1:0] in_sel,
  input  logic [SUM_W-1:0]   min_value,
  input  logic [SUM_W-1:0]   max_weight,
  input  logic [SUM_W-1:0]   max_volume,
  output logic               out_vld,
  output logic [N_ITEMS-1:0] out_sel,
  output logic [SUM_W-1:0]   out_value,
  output logic               out_feas
);

  logic [SUM_W-1:0] sum_value;
  logic [SUM_W-1:0] sum_weight;
  logic [SUM_W-1:0] sum_volume;
  logic             feas;

  always_comb begin
    sum_value  = '0;
    sum_weight = '0;
    sum_volume = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (in_sel[i]) begin
        sum_value  = sum_value  + SUM_W'(items[i].value);
        sum_weight = sum_weight + SUM_W'(items[i].weight);
        sum_volume = sum_volume + SUM_W'(items[i].volume);
      end
    end
    feas = (sum_value >= min_value) && (sum_weight <= max_weight) &&
           (sum_volume <= max_volume);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_sel   <= '0;
      out_value <= '0;
      out_feas  <= 1'b0;
    end else begin
      out_vld   <= in_vld;
      out_sel   <= in_sel;
      out_value <= sum_value;
      out_feas  <= in_vld && feas;
    end
  end

endmodule

// File: rtl/knap_search_ctrl.sv
// Exhaustive subset search: item table, candidate enumeration, best/count tracking.
module knap_search_ctrl
  import knap_pkg::*;
#(
  parameter int unsigned N_ITEMS = KNAP_N_ITEMS,
  parameter int unsigned ATTR_W  = KNAP_ATTR_W,
  parameter int unsigned SUM_W   = knap_sum_w(ATTR_W, N_ITEMS)
) (
  input logic               clk,
  input logic               rst_n,
  knap_search_ctrl_if.slave bus
);

  knap_state_e        state;
  item_t              items [N_ITEMS];
  logic [N_ITEMS-1:0] cand;
  logic [N_ITEMS-1:0] sel_q;
  logic               sel_vld;
  logic [SUM_W-1:0]   min_value_q;
  logic [SUM_W-1:0]   max_weight_q;
  logic [SUM_W-1:0]   max_volume_q;
  logic               first_only_q;

  logic               res_vld;
  logic [N_ITEMS-1:0] res_sel;
  logic [SUM_W-1:0]   res_value;
  logic               res_feas;

  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic [N_ITEMS-1:0] best_sel_q;
  logic [SUM_W-1:0]   best_value_q;
  logic [N_ITEMS:0]   feas_count_q;

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.found      = found_q;
  assign bus.best_sel   = best_sel_q;
  assign bus.best_value = best_value_q;
  assign bus.feas_count = feas_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        items[i] <= '0;
      end
    end else if (bus.cfg_we && !busy_q && (32'(bus.cfg_idx) < N_ITEMS)) begin
      items[bus.cfg_idx] <= '{value:  bus.cfg_value,
                              weight: bus.cfg_weight,
                              volume: bus.cfg_volume};
    end
  end

  knap_eval #(
    .N_ITEMS (N_ITEMS),
    .SUM_W   (SUM_W)
  ) u_eval (
    .clk        (clk),
    .rst_n      (rst_n),
    .items      (items),
    .in_vld     (sel_vld),
    .in_sel     (sel_q),
    .min_value  (min_value_q),
    .max_weight (max_weight_q),
    .max_volume (max_volume_q),
    .out_vld    (res_vld),
    .out_sel    (res_sel),
    .out_value  (res_value),
    .out_feas   (res_feas)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cand         <= '0;
      sel_q        <= '0;
      sel_vld      <= 1'b0;
      min_value_q  <= '0;
      max_weight_q <= '0;
      max_volume_q <= '0;
      first_only_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      best_sel_q   <= '0;
      best_value_q <= '0;
      feas_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          sel_vld <= 1'b0;
          done_q  <= 1'b0;
          if (bus.start) begin
            state        <= ST_RUN;
            busy_q       <= 1'b1;
            min_value_q  <= bus.min_value;
            max_weight_q <= bus.max_weight;
            max_volume_q <= bus.max_volume;
            first_only_q <= bus.first_only;
            cand         <= '0;
            found_q      <= 1'b0;
            best_sel_q   <= '0;
            best_value_q <= '0;
            feas_count_q <= '0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (bus.abort) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            sel_vld <= 1'b0;
          end else begin
            if (state == ST_RUN) begin
              sel_q   <= cand;
              sel_vld <= 1'b1;
              cand    <= cand + N_ITEMS'(1);
              if (cand == '1) state <= ST_DRAIN;
            end else begin
              sel_vld <= 1'b0;
            end

            // Ascending enumeration plus strict '>' keeps the lowest index on ties.
            if (res_vld && res_feas) begin
              found_q      <= 1'b1;
              feas_count_q <= feas_count_q + (N_ITEMS+1)'(1);
              if (!found_q || (res_value > best_value_q)) begin
                best_sel_q   <= res_sel;
                best_value_q <= res_value;
              end
            end

            // Overrides the issue-path state update; in-flight candidates are dropped.
            if ((res_vld && res_feas && first_only_q) ||
                (state == ST_DRAIN && !sel_vld && res_vld)) begin
              state   <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sel_vld <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          sel_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Randomized self-checking bench for knap_search_ctrl against a subset-enumeration model.
module tb_knap_search_ctrl;
  import knap_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned SW = knap_sum_w(AW, N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  knap_search_ctrl_if #(.N_ITEMS(N), .ATTR_W(AW)) bus ();

  knap_search_ctrl #(.N_ITEMS(N), .ATTR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tv [N];
  int tw [N];
  int tm [N];
  int minv, maxw, maxm;
  int e_found, e_sel, e_val, e_cnt, e_edge;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk subsets 0..last_k in order, applying the feasibility and best rules.
  task automatic model(input bit fo, input int last_k);
    int sv, sw, sm;
    e_found = 0; e_sel = 0; e_val = 0; e_cnt = 0;
    e_edge  = (1 << N) + 2;
    for (int k = 0; k <= last_k; k++) begin
      sv = 0; sw = 0; sm = 0;
      for (int i = 0; i < N; i++) begin
        if (((k >> i) & 1) == 1) begin
          sv += tv[i]; sw += tw[i]; sm += tm[i];
        end
      end
      if (sv >= minv && sw <= maxw && sm <= maxm) begin
        e_cnt++;
        if (e_found == 0 || sv > e_val) begin
          e_sel = k;
          e_val = sv;
        end
        e_found = 1;
        if (fo) begin
          e_edge = k + 3;
          break;
        end
      end
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      bus.cfg_we     = 1'b1;
      bus.cfg_idx    = 2'(i);
      bus.cfg_value  = AW'(tv[i]);
      bus.cfg_weight = AW'(tw[i]);
      bus.cfg_volume = AW'(tm[i]);
      tick();
    end
    bus.cfg_we = 1'b0;
  endtask

  task automatic drive_thr();
    bus.min_value  = SW'(minv);
    bus.max_weight = SW'(maxw);
    bus.max_volume = SW'(maxm);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_found"}, bus.found, e_found);
    chk({tag, "_sel"}, bus.best_sel, e_sel);
    chk({tag, "_val"}, bus.best_value, e_val);
    chk({tag, "_cnt"}, bus.feas_count, e_cnt);
  endtask

  // Ends at the sample just after the done edge; pre means start is raised in the done cycle.
  task automatic run_search(input bit fo, input bit pre, input bit poke, input string tag);
    int de;
    model(fo, (1 << N) - 1);
    drive_thr();
    bus.first_only = fo;
    bus.start      = 1'b1;
    if (pre) begin
      tick();
      chk({tag, "_gap_done"}, bus.done, 0);
      chk({tag, "_gap_busy"}, bus.busy, 0);
    end
    tick();
    bus.start = 1'b0;
    de = -1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 1) chk({tag, "_busy"}, bus.busy, 1);
      if (poke && e == 4) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = 2'd0;
        bus.cfg_value  = 9'd300;
        bus.cfg_weight = 9'd0;
        bus.cfg_volume = 9'd0;
        bus.start      = 1'b1;
      end
      if (poke && e == 5) begin
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
      end
      if (bus.done) begin
        de = e;
        break;
      end
    end
    chk({tag, "_done_edge"}, 64'(de), 64'(e_edge));
    chk({tag, "_busy_at_done"}, bus.busy, 0);
    check_result(tag);
  endtask

  task automatic idle_gap(input string tag);
    tick();
    chk({tag, "_pulse"}, bus.done, 0);
    tick();
  endtask

  task automatic run_abort(input int a_edge, input string tag);
    bit seen;
    model(0, a_edge - 4);
    drive_thr();
    bus.first_only = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int e = 1; e < a_edge; e++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk({tag, "_busy"}, bus.busy, 0);
    seen = bus.done;
    repeat (4) begin
      tick();
      seen = seen | bus.done;
    end
    chk({tag, "_nodone"}, seen, 0);
    check_result(tag);
  endtask

  task automatic spec_table();
    tv = '{4, 8, 20, 10};
    tw = '{28, 8, 18, 27};
    tm = '{27, 27, 4, 0};
    minv = 20; maxw = 60; maxm = 60;
    load_table();
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_idx = '0;
    bus.cfg_value = '0; bus.cfg_weight = '0; bus.cfg_volume = '0;
    bus.min_value = '0; bus.max_weight = '0; bus.max_volume = '0;
    bus.first_only = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_sel", bus.best_sel, 0);
    chk("rst_val", bus.best_value, 0);
    chk("rst_cnt", bus.feas_count, 0);

    spec_table();
    run_search(0, 0, 0, "full");
    chk("full_sel_lit", bus.best_sel, 4'b1110);
    chk("full_val_lit", bus.best_value, 38);
    chk("full_cnt_lit", bus.feas_count, 6);
    run_search(1, 1, 0, "first");
    chk("first_sel_lit", bus.best_sel, 4'b0100);
    chk("first_cnt_lit", bus.feas_count, 1);
    idle_gap("first");

    minv = 50;
    run_search(0, 0, 0, "nofeas");
    chk("nofeas_found_lit", bus.found, 0);
    idle_gap("nofeas");

    tv = '{5, 5, 5, 5};
    tw = '{0, 0, 0, 0};
    tm = '{1, 1, 1, 1};
    minv = 5; maxw = 0; maxm = 3;
    load_table();
    run_search(0, 0, 0, "tie");
    chk("tie_sel_lit", bus.best_sel, 4'b0111);
    idle_gap("tie");

    spec_table();
    run_abort(7, "abort7");
    run_abort(int'($urandom_range(8, 17)), "abort_rnd");
    run_search(0, 0, 0, "after_abort");
    idle_gap("after_abort");

    run_search(0, 0, 1, "poke");
    idle_gap("poke");
    chk("poke_start_ignored", bus.busy, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        tv[i] = int'($urandom_range(0, 511));
        tw[i] = int'($urandom_range(0, 511));
        tm[i] = int'($urandom_range(0, 511));
      end
      minv = int'($urandom_range(0, 1500));
      maxw = int'($urandom_range(0, 2000));
      maxm = int'($urandom_range(0, 2000));
      load_table();
      run_search(1'($urandom_range(0, 1)), 0, 0, "rnd");
      idle_gap("rnd");
    end

    spec_table();
    bus.first_only = 1'b0;
    drive_thr();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_found", bus.found, 0);
    chk("arst_sel", bus.best_sel, 0);
    chk("arst_val", bus.best_value, 0);
    chk("arst_cnt", bus.feas_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    tv = '{0, 0, 0, 0};
    tw = '{0, 0, 0, 0};
    tm = '{0, 0, 0, 0};
    minv = 0; maxw = 0; maxm = 0;
    run_search(0, 0, 0, "cleared_table");
    idle_gap("cleared_table");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
